// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encoding, source indices and clog2 helper for the display scheduler
package display_pkg;

  typedef enum logic {
    SHOW   = 1'b0,
    URGENT = 1'b1
  } state_t;

  localparam int SRC_PC  = 0;
  localparam int SRC_REG = 1;
  localparam int SRC_CYC = 2;
  localparam int SRC_SYS = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = display_pkg::clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest request at or after ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - shares one 8-digit display between sources with rotation and urgent round-robin pre-emption
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int ROTATE_TICKS = 2000,
  parameter int HOLD_TICKS   = 3000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [32*NUM_SRC-1:0]       src_data,
  input  logic [NUM_SRC-1:0]          src_radix,
  input  logic [NUM_SRC-1:0]          src_req,
  output logic [NUM_SRC-1:0]          src_ack,
  input  logic                        sel_next,
  input  logic                        auto_en,
  output logic [31:0]                 data_out,
  output logic                        radix_out,
  output logic [clog2(NUM_SRC)-1:0]   active_src,
  output logic                        urgent
);

  localparam int IW = clog2(NUM_SRC);
  localparam int RW = (clog2(ROTATE_TICKS) < 1) ? 1 : clog2(ROTATE_TICKS);
  localparam int HW = (clog2(HOLD_TICKS) < 1) ? 1 : clog2(HOLD_TICKS);
  localparam logic [RW-1:0] ROT_LAST  = RW'(ROTATE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t           state, state_nx;
  logic [IW-1:0]    cur_sel, cur_sel_nx;
  logic [IW-1:0]    rr_ptr, rr_ptr_nx;
  logic [IW-1:0]    win_idx, win_idx_nx;
  logic [RW-1:0]    rot_cnt, rot_cnt_nx;
  logic [HW-1:0]    hold_cnt, hold_cnt_nx;
  logic [NUM_SRC-1:0] ack_nx;
  logic [NUM_SRC-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_SRC - 1)) ? '0 : v + 1'b1;
  endfunction

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_arbiter (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    state_nx    = state;
    cur_sel_nx  = cur_sel;
    rr_ptr_nx   = rr_ptr;
    win_idx_nx  = win_idx;
    rot_cnt_nx  = rot_cnt;
    hold_cnt_nx = hold_cnt;
    ack_nx      = '0;
    case (state)
      SHOW: begin
        // Urgent entry outranks selection changes arriving in the same cycle.
        if (arb_any) begin
          state_nx    = URGENT;
          win_idx_nx  = arb_idx;
          rr_ptr_nx   = wrap_inc(arb_idx);
          hold_cnt_nx = '0;
          ack_nx      = arb_grant;
        end else if (sel_next) begin
          cur_sel_nx = wrap_inc(cur_sel);
          rot_cnt_nx = '0;
        end else if (auto_en && tick) begin
          if (rot_cnt == ROT_LAST) begin
            cur_sel_nx = wrap_inc(cur_sel);
            rot_cnt_nx = '0;
          end else begin
            rot_cnt_nx = rot_cnt + 1'b1;
          end
        end
      end
      URGENT: begin
        if (sel_next) begin
          cur_sel_nx = wrap_inc(cur_sel);
        end
        if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx   = SHOW;
            rot_cnt_nx = '0;
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
      end
      default: state_nx = SHOW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= SHOW;
      cur_sel  <= '0;
      rr_ptr   <= '0;
      win_idx  <= '0;
      rot_cnt  <= '0;
      hold_cnt <= '0;
      src_ack  <= '0;
    end else begin
      state    <= state_nx;
      cur_sel  <= cur_sel_nx;
      rr_ptr   <= rr_ptr_nx;
      win_idx  <= win_idx_nx;
      rot_cnt  <= rot_cnt_nx;
      hold_cnt <= hold_cnt_nx;
      src_ack  <= ack_nx;
    end
  end

  assign urgent     = (state == URGENT);
  assign active_src = urgent ? win_idx : cur_sel;

  // Live values: the displayed source's inputs are re-sampled every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out  <= '0;
      radix_out <= 1'b0;
    end else begin
      data_out  <= src_data[32*int'(active_src) +: 32];
      radix_out <= src_radix[active_src];
    end
  end

endmodule
